muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit for the Execute stage. It accepts one M-extension operation through a valid/ready request, computes it over 32 cycles with a radix-2 shift-add or restoring-divide datapath, and returns the result through a valid/ready response. It takes M-ops off the single-cycle combinational path, and Execute stalls while the request is outstanding.

---
 rtl/muldiv_pkg.sv | 37 +++
 rtl/muldiv_unit.sv | 177 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared types and constants for the iterative RV32M unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  localparam int XLEN_C = 32;

  localparam logic [XLEN_C-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [XLEN_C-1:0] INT_MIN    = 32'h8000_0000;

  // Encodings follow the funct3 field of the M-extension opcodes.
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  function automatic logic is_div_op(input muldiv_op_e o);
    return o[2];
  endfunction

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide, one radix-2 step per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_C
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  muldiv_state_e   r_state;
  muldiv_op_e      r_op;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic            r_neg;
  logic [4:0]      r_cnt;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [XLEN-1:0] r_result;

  muldiv_op_e        w_op_in;
  logic              w_a_signed;
  logic              w_b_signed;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_neg_in;
  logic              w_b_zero;
  logic              w_ovf;
  logic              w_fast;
  logic [XLEN-1:0]   w_fast_result;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_shift;
  logic              w_ge;
  logic [XLEN-1:0]   w_hi_nxt;
  logic [XLEN-1:0]   w_lo_nxt;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_div_res;
  logic [XLEN-1:0]   w_div_s;
  logic [XLEN-1:0]   w_final;

  // Accept-side decode: magnitudes, result sign and the special cases.
  always_comb begin
    w_op_in    = muldiv_op_e'(op);
    w_a_signed = (w_op_in == OP_MULH) || (w_op_in == OP_MULHSU) ||
                 (w_op_in == OP_DIV)  || (w_op_in == OP_REM);
    w_b_signed = (w_op_in == OP_MULH) || (w_op_in == OP_DIV) || (w_op_in == OP_REM);
    w_a_mag    = (w_a_signed && operand_a[XLEN-1]) ? -operand_a : operand_a;
    w_b_mag    = (w_b_signed && operand_b[XLEN-1]) ? -operand_b : operand_b;
    case (w_op_in)
      OP_MULH, OP_DIV: w_neg_in = operand_a[XLEN-1] ^ operand_b[XLEN-1];
      OP_MULHSU, OP_REM: w_neg_in = operand_a[XLEN-1];
      default:         w_neg_in = 1'b0;
    endcase
    w_b_zero = (operand_b == '0);
    w_ovf    = ((w_op_in == OP_DIV) || (w_op_in == OP_REM)) &&
               (operand_a == INT_MIN) && (operand_b == '1);
    w_fast   = is_div_op(w_op_in) && (w_b_zero || w_ovf);
    if (w_b_zero) begin
      w_fast_result = w_op_in[1] ? operand_a : DIV_ZERO_Q;
    end else begin
      w_fast_result = w_op_in[1] ? '0 : INT_MIN;
    end
  end

  // One iteration: r_hi/r_lo hold {acc_hi, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
    w_shift = {r_hi, r_lo[XLEN-1]};
    w_ge    = (w_shift >= {1'b0, r_b});
    if (is_div_op(r_op)) begin
      w_hi_nxt = w_ge ? (w_shift[XLEN-1:0] - r_b) : w_shift[XLEN-1:0];
      w_lo_nxt = {r_lo[XLEN-2:0], w_ge};
    end else begin
      w_hi_nxt = w_sum[XLEN:1];
      w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
    end
    w_prod    = {w_hi_nxt, w_lo_nxt};
    w_prod_s  = r_neg ? -w_prod : w_prod;
    w_div_res = r_op[1] ? w_hi_nxt : w_lo_nxt;
    w_div_s   = r_neg ? -w_div_res : w_div_res;
    if (is_div_op(r_op)) begin
      w_final = w_div_s;
    end else if (r_op == OP_MUL) begin
      w_final = w_prod_s[XLEN-1:0];
    end else begin
      w_final = w_prod_s[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_op        <= OP_MUL;
      r_a         <= '0;
      r_b         <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_neg       <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
    end else if (flush) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op       <= w_op_in;
            r_a        <= w_a_mag;
            r_b        <= w_b_mag;
            r_neg      <= w_neg_in;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            if (w_fast) begin
              r_result    <= w_fast_result;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_hi    <= '0;
              r_lo    <= is_div_op(w_op_in) ? w_a_mag : w_b_mag;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_result    <= w_final;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;

endmodule : muldiv_unit
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int checks;
  int failures;

  muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Issue one op from the point #1 after a rising edge; exp_lat counts edges after the accept edge.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input int hold,
                        input string tag);
    int lat;
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    op        = o;
    operand_a = a;
    operand_b = b;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    op        = 3'b011;
    operand_a = $urandom;
    operand_b = $urandom;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_res"}, result, exp);
    for (int i = 0; i < hold; i++) begin
      in_valid  = 1'b1;
      op        = 3'b101;
      operand_a = 32'd1;
      operand_b = 32'd1;
      @(posedge clk); #1;
      check_eq({tag, "_hold_res"}, result, exp);
      check_eq({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
      check_eq({tag, "_hold_vld"}, 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, "_drain_vld"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_drain_rdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int seen;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 3'b000;
    operand_a = '0;
    operand_b = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #12;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(3'b000, 32'd7,          32'd6,          32'd42,         32, 0, "mul");
    run_op(3'b001, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  32, 0, "mulh");
    run_op(3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32, 0, "mulhu");
    run_op(3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32, 0, "mulhsu");
    run_op(3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32, 0, "div_neg");
    run_op(3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32, 0, "rem_neg");
    run_op(3'b101, 32'd100,        32'd7,          32'd14,         32, 0, "divu");
    run_op(3'b111, 32'd100,        32'd7,          32'd2,          32, 0, "remu");
    run_op(3'b100, 32'd5,          32'd0,          32'hFFFF_FFFF,  0,  0, "div_by0");
    run_op(3'b110, 32'd5,          32'd0,          32'd5,          0,  0, "rem_by0");
    run_op(3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0,  0, "div_ovf");
    run_op(3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          0,  0, "rem_ovf");
    run_op(3'b101, 32'd100,        32'd7,          32'd14,         32, 10, "bp");

    // Kill during iteration 10: accept at E0, flush sampled at E11.
    in_valid  = 1'b1;
    op        = 3'b000;
    operand_a = 32'd1234;
    operand_b = 32'd5678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("flush_in_ready", 32'(in_ready), 32'd1);
    check_eq("flush_out_valid", 32'(out_valid), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_eq("flush_no_result", 32'(seen), 32'd0);
    run_op(3'b101, 32'd9, 32'd3, 32'd3, 32, 0, "post_flush_divu");

    // Asynchronous reset in the middle of an operation.
    in_valid  = 1'b1;
    op        = 3'b000;
    operand_a = 32'd3;
    operand_b = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(3'b111, 32'd17, 32'd5, 32'd2, 32, 0, "post_rst_remu");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_muldiv_unit
`default_nettype wire
